// File: rtl/sha1_msg_loader.sv
// Streams message bytes into the dpsram as little-endian words, kicks the
// SHA-1 core, then copies the five digest words back to the result area.
module sha1_msg_loader (
    input  logic         clk,
    input  logic         nreset,
    input  logic         start,
    input  logic [31:0]  base_addr,
    input  logic [31:0]  result_addr,
    output logic         busy,
    output logic         finished,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    input  logic         byte_last,
    output logic         byte_ready,
    output logic         port_B_clk,
    output logic [15:0]  port_B_addr,
    output logic [31:0]  port_B_data_in,
    output logic         port_B_we,
    output logic         start_hash,
    output logic [31:0]  message_addr,
    output logic [31:0]  message_size,
    input  logic [159:0] hash,
    input  logic         done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        KICK,
        WAIT,
        WRITE,
        FIN
    } state_t;

    state_t state, state_nxt;

    logic [31:0] base_q;
    logic [15:0] result_base;
    logic [31:0] count;
    logic [31:0] pack;
    logic [31:0] pack_merged;
    logic [1:0]  lane;
    logic [15:0] word_addr;
    logic        accept;
    logic        word_done;

    logic        ld_we;
    logic [15:0] ld_addr;
    logic [31:0] ld_data;

    logic        wait_armed;
    logic [2:0]  wr_idx;
    logic [31:0] hash_word;
    logic        wr_active;

    logic        unused;
    assign unused = ^result_addr[31:16];

    assign port_B_clk   = clk;
    assign message_addr = base_q;
    assign message_size = count;

    assign lane      = count[1:0];
    assign accept    = byte_valid && byte_ready;
    assign word_done = (lane == 2'd3) || byte_last;
    assign word_addr = base_q[15:0] + {count[15:2], 2'b00};

    // Upper lanes of pack are already zero, so a partial last word pads itself.
    always_comb begin
        pack_merged = pack;
        pack_merged[{lane, 3'b000} +: 8] = byte_in;
    end

    always_comb begin
        case (wr_idx)
            3'd0:    hash_word = hash[159:128];
            3'd1:    hash_word = hash[127:96];
            3'd2:    hash_word = hash[95:64];
            3'd3:    hash_word = hash[63:32];
            default: hash_word = hash[31:0];
        endcase
    end

    assign wr_active      = (state == WRITE);
    assign port_B_we      = wr_active || ld_we;
    assign port_B_addr    = wr_active ? result_base + {11'b0, wr_idx, 2'b00}
                                      : ld_addr;
    assign port_B_data_in = wr_active ? hash_word : ld_data;

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        finished   = 1'b0;
        byte_ready = 1'b0;
        start_hash = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (byte_valid && byte_last)
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                busy      = 1'b1;
                state_nxt = KICK;
            end
            KICK: begin
                busy       = 1'b1;
                start_hash = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_armed && done)
                    state_nxt = WRITE;
            end
            WRITE: begin
                busy = 1'b1;
                if (wr_idx == 3'd4)
                    state_nxt = FIN;
            end
            FIN: begin
                finished  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            base_q      <= '0;
            result_base <= '0;
            count       <= '0;
            pack        <= '0;
            ld_we       <= 1'b0;
            ld_addr     <= '0;
            ld_data     <= '0;
            wait_armed  <= 1'b0;
            wr_idx      <= '0;
        end else begin
            state <= state_nxt;
            ld_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q      <= base_addr;
                        result_base <= result_addr[15:0];
                        count       <= '0;
                        pack        <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        count <= count + 32'd1;
                        if (word_done) begin
                            ld_we   <= 1'b1;
                            ld_addr <= word_addr;
                            ld_data <= pack_merged;
                            pack    <= '0;
                        end else begin
                            pack <= pack_merged;
                        end
                    end
                end
                // A done left high by the previous run is masked for one cycle.
                KICK: wait_armed <= 1'b0;
                WAIT: begin
                    wait_armed <= 1'b1;
                    wr_idx     <= '0;
                end
                WRITE: wr_idx <= wr_idx + 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_msg_loader.sv
// Bench for sha1_msg_loader: event-level model checked every cycle plus
// literal memory-image checks for the directed runs.
module tb_sha1_msg_loader;

    logic         clk = 1'b0;
    logic         nreset;
    logic         start;
    logic [31:0]  base_addr;
    logic [31:0]  result_addr;
    logic         busy;
    logic         finished;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_last;
    logic         byte_ready;
    logic         port_B_clk;
    logic [15:0]  port_B_addr;
    logic [31:0]  port_B_data_in;
    logic         port_B_we;
    logic         start_hash;
    logic [31:0]  message_addr;
    logic [31:0]  message_size;
    logic [159:0] hash;
    logic         done;

    localparam logic [159:0] ABC =
        160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
    localparam logic [159:0] H2 =
        160'h01234567_89ABCDEF_FEDCBA98_76543210_F0E1D2C3;

    sha1_msg_loader dut (
        .clk(clk),
        .nreset(nreset),
        .start(start),
        .base_addr(base_addr),
        .result_addr(result_addr),
        .busy(busy),
        .finished(finished),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_last(byte_last),
        .byte_ready(byte_ready),
        .port_B_clk(port_B_clk),
        .port_B_addr(port_B_addr),
        .port_B_data_in(port_B_data_in),
        .port_B_we(port_B_we),
        .start_hash(start_hash),
        .message_addr(message_addr),
        .message_size(message_size),
        .hash(hash),
        .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory image and write/finish counters, captured from the port
    logic [31:0] mem [logic [15:0]];
    int wr_total = 0;
    int fin_total = 0;

    function automatic logic [31:0] rd(input logic [15:0] a);
        if (mem.exists(a))
            return mem[a];
        return 32'hDEADBEEF;
    endfunction

    always @(negedge clk) begin
        if (nreset && port_B_we) begin
            mem[port_B_addr] = port_B_data_in;
            wr_total++;
        end
        if (nreset && finished)
            fin_total++;
    end

    // Behavioural model: event times derived from the accepted byte stream
    int          cyc = 0;
    bit          m_active = 0;
    bit          m_loading = 0;
    logic [31:0] m_base = '0;
    logic [31:0] m_res = '0;
    logic [7:0]  m_msg[$];
    int          ld_cyc = -1;
    logic [15:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    int          kick_cyc = -1;
    int          wr_start = -1;
    int          fin_cyc = -1;

    function automatic logic [31:0] hw(input int i);
        logic [159:0] t;
        t = hash >> (32 * (4 - i));
        return t[31:0];
    endfunction

    always @(negedge clk) begin : cmp
        logic        ew;
        logic [15:0] ea;
        logic [31:0] ed;
        bit          acc;
        int          n, w;
        if (!nreset) begin
            chk("rst_ctrl", 64'({busy, finished, byte_ready, port_B_we,
                                 start_hash}), 64'd0);
            chk("rst_addr", 64'(port_B_addr), 64'd0);
            chk("rst_data", 64'(port_B_data_in), 64'd0);
            chk("rst_maddr", 64'(message_addr), 64'd0);
            chk("rst_msize", 64'(message_size), 64'd0);
            m_active  = 0;
            m_loading = 0;
            m_msg.delete();
            ld_cyc    = -1;
            kick_cyc  = -1;
            wr_start  = -1;
            fin_cyc   = -1;
        end else begin
            ew = 0;
            ea = '0;
            ed = '0;
            if (cyc == ld_cyc) begin
                ew = 1;
                ea = ld_addr;
                ed = ld_data;
            end else if (wr_start >= 0 && cyc >= wr_start &&
                         cyc <= wr_start + 4) begin
                ew = 1;
                ea = m_res[15:0] + 16'(4 * (cyc - wr_start));
                ed = hw(cyc - wr_start);
            end
            chk("we", 64'(port_B_we), 64'(ew));
            if (ew) begin
                chk("addr", 64'(port_B_addr), 64'(ea));
                chk("data", 64'(port_B_data_in), 64'(ed));
            end
            chk("byte_ready", 64'(byte_ready), 64'(m_loading));
            chk("busy", 64'(busy), 64'(m_active && cyc != fin_cyc));
            chk("finished", 64'(finished), 64'(cyc == fin_cyc));
            chk("start_hash", 64'(start_hash),
                64'(kick_cyc >= 0 && cyc == kick_cyc));
            if (m_active && kick_cyc >= 0 && cyc >= kick_cyc) begin
                chk("message_size", 64'(message_size), 64'(m_msg.size()));
                chk("message_addr", 64'(message_addr), 64'(m_base));
            end
            acc = m_loading && byte_valid;
            if (!m_active && start) begin
                m_active  = 1;
                m_loading = 1;
                m_base    = base_addr;
                m_res     = result_addr;
                m_msg.delete();
                ld_cyc    = -1;
                kick_cyc  = -1;
                wr_start  = -1;
                fin_cyc   = -1;
            end
            if (acc) begin
                m_msg.push_back(byte_in);
                n = m_msg.size();
                if (n % 4 == 0 || byte_last) begin
                    w       = (n - 1) / 4;
                    ld_cyc  = cyc + 1;
                    ld_addr = m_base[15:0] + 16'(4 * w);
                    ld_data = '0;
                    for (int k = 0; k < 4; k++)
                        if (4 * w + k < n)
                            ld_data = ld_data |
                                (32'(m_msg[4 * w + k]) << (8 * k));
                end
                if (byte_last) begin
                    m_loading = 0;
                    kick_cyc  = cyc + 2;
                end
            end
            if (kick_cyc >= 0 && wr_start < 0 && cyc >= kick_cyc + 2 && done)
            begin
                wr_start = cyc + 1;
                fin_cyc  = cyc + 6;
            end
            if (cyc == fin_cyc) begin
                m_active = 0;
                kick_cyc = -1;
                wr_start = -1;
                fin_cyc  = -1;
            end
        end
        cyc++;
    end

    // Stimulus
    logic [7:0] tx[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] r);
        start       = 1'b1;
        base_addr   = b;
        result_addr = r;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input bit gaps, input int poke_at, input bit with_last);
        int guard;
        for (int i = 0; i < tx.size(); i++) begin
            if (gaps) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            byte_valid = 1'b1;
            byte_in    = tx[i];
            byte_last  = with_last && (i == tx.size() - 1);
            if (i == poke_at) begin
                start       = 1'b1;
                base_addr   = 32'h0000_7777;
                result_addr = 32'h0000_8888;
            end
            guard = 0;
            while (!byte_ready && guard < 20) begin
                tick();
                guard++;
            end
            if (guard >= 20)
                chk("ready_timeout", 64'd0, 64'd1);
            tick();
            start = 1'b0;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic core(input bit stale, input logic [159:0] h);
        int g;
        int w0;
        g = 0;
        hash = h;
        while (!start_hash && g < 200) begin
            tick();
            g++;
        end
        if (g >= 200) begin
            chk("kick_timeout", 64'd0, 64'd1);
            return;
        end
        if (stale) begin
            tick();
            tick();
            done = 1'b0;
            w0 = wr_total;
            repeat (3) tick();
            chk("stale_done_no_write", 64'(wr_total), 64'(w0));
        end else begin
            done = 1'b0;
            repeat (4) tick();
        end
        done = 1'b1;
    endtask

    task automatic wait_fin();
        int g;
        g = 0;
        while (!finished && g < 100) begin
            tick();
            g++;
        end
        chk("finished_seen", 64'(finished), 64'd1);
        tick();
    endtask

    task automatic run(input logic [31:0] b, input logic [31:0] r,
                       input bit gaps, input int poke, input bit junk,
                       input bit stale, input logic [159:0] h);
        if (junk) begin
            byte_valid = 1'b1;
            byte_in    = 8'hEE;
            repeat (2) tick();
        end
        do_start(b, r);
        send(gaps, poke, 1'b1);
        if (junk) begin
            byte_valid = 1'b1;
            byte_in    = 8'hEE;
        end
        core(stale, h);
        wait_fin();
        byte_valid = 1'b0;
    endtask

    task automatic check_abc();
        int w0, f0;
        mem.delete();
        w0 = wr_total;
        f0 = fin_total;
        tx = '{8'h61, 8'h62, 8'h63};
        run(32'h0, 32'h100, 0, -1, 0, 0, ABC);
        chk("abc_word", 64'(rd(16'h0000)), 64'h00636261);
        chk("abc_h0", 64'(rd(16'h0100)), 64'hA9993E36);
        chk("abc_h1", 64'(rd(16'h0104)), 64'h4706816A);
        chk("abc_h2", 64'(rd(16'h0108)), 64'hBA3E2571);
        chk("abc_h3", 64'(rd(16'h010C)), 64'h7850C26C);
        chk("abc_h4", 64'(rd(16'h0110)), 64'h9CD0D89D);
        chk("abc_writes", 64'(wr_total - w0), 64'd6);
        chk("abc_size", 64'(message_size), 64'd3);
        chk("abc_fin", 64'(fin_total - f0), 64'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] snap[3];
        int w0;
        nreset      = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        result_addr = '0;
        byte_in     = '0;
        byte_valid  = 1'b0;
        byte_last   = 1'b0;
        hash        = '0;
        done        = 1'b0;
        #2 nreset = 1'b0;
        repeat (3) tick();
        nreset = 1'b1;
        tick();

        check_abc();

        mem.delete();
        w0 = wr_total;
        tx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run(32'hFFFC, 32'h1000, 0, -1, 0, 0, H2);
        chk("wrap_w0", 64'(rd(16'hFFFC)), 64'h04030201);
        chk("wrap_w1", 64'(rd(16'h0000)), 64'h08070605);
        chk("wrap_loads", 64'(wr_total - w0 - 5), 64'd2);
        chk("wrap_size", 64'(message_size), 64'd8);

        mem.delete();
        tx = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14,
               8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
        run(32'h0200, 32'h2000, 0, -1, 0, 0, H2);
        for (int i = 0; i < 3; i++)
            snap[i] = rd(16'h0200 + 16'(4 * i));
        chk("img_tail", 64'(snap[2]), 64'h00001918);
        mem.delete();
        run(32'h0200, 32'h2000, 1, -1, 1, 0, H2);
        for (int i = 0; i < 3; i++)
            chk("img_gaps", 64'(rd(16'h0200 + 16'(4 * i))), 64'(snap[i]));
        chk("img_size", 64'(message_size), 64'd10);

        tx = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        run(32'h0300, 32'h2100, 0, -1, 0, 1, ABC);
        chk("stale_size", 64'(message_size), 64'd5);
        chk("stale_h4", 64'(rd(16'h2110)), 64'h9CD0D89D);

        mem.delete();
        tx = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        run(32'h0500, 32'h3000, 0, 2, 0, 0, H2);
        chk("poke_maddr", 64'(message_addr), 64'h0500);
        chk("poke_w1", 64'(rd(16'h0504)), 64'h0000C5C4);
        chk("poke_h0", 64'(rd(16'h3000)), 64'h01234567);
        chk("poke_stray", 64'(mem.exists(16'h7777)), 64'd0);

        tx = '{8'hAB};
        run(32'h0600, 32'h3100, 0, -1, 0, 0, H2);
        chk("one_word", 64'(rd(16'h0600)), 64'h000000AB);
        chk("one_size", 64'(message_size), 64'd1);

        do_start(32'h0700, 32'h0100);
        tx = '{8'h01, 8'h02};
        send(0, -1, 0);
        w0 = wr_total;
        nreset = 1'b0;
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        tick();
        nreset = 1'b1;
        repeat (5) tick();
        chk("rst_no_write", 64'(wr_total), 64'(w0));
        check_abc();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
